// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: memop codes, FSM states, reset constants
// and small decode helpers used by the stage and its load extender.
package mem_stage_pkg;

   localparam int          ByteBus      = 8;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr   = 5'd0;
   localparam logic        WriteDisable = 1'b0;

   typedef enum logic [3:0] {
      MEM_NONE = 4'h0,
      MEM_LB   = 4'h1,
      MEM_LH   = 4'h2,
      MEM_LW   = 4'h3,
      MEM_LBU  = 4'h4,
      MEM_LHU  = 4'h5,
      MEM_SB   = 4'h6,
      MEM_SH   = 4'h7,
      MEM_SW   = 4'h8
   } memop_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic is_load(input logic [3:0] op);
      case (op)
         MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      case (op)
         MEM_SB, MEM_SH, MEM_SW: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   // Index of the final byte of the access, i.e. N-1.
   function automatic logic [1:0] last_byte(input logic [3:0] op);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
         MEM_LW, MEM_SW:          return 2'd3;
         default:                 return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational sign/zero extension of the assembled load buffer.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [3:0]  memop_i,
   input  logic [31:0] buf_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = buf_i;
      case (memop_i)
         MEM_LB:  data_o = {{24{buf_i[7]}}, buf_i[7:0]};
         MEM_LBU: data_o = {24'd0, buf_i[7:0]};
         MEM_LH:  data_o = {{16{buf_i[15]}}, buf_i[15:0]};
         MEM_LHU: data_o = {16'd0, buf_i[15:0]};
         default: data_o = buf_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: serialises loads/stores onto a byte-wide RAM handshake,
// stalling upstream until the access completes; non-memory ops pass straight through.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         wd_i,
   input  logic               wreg_i,
   input  logic [31:0]        wdata_i,
   input  logic [3:0]         memop_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        sdata_i,
   output logic [4:0]         wd_o,
   output logic               wreg_o,
   output logic [31:0]        wdata_o,
   output logic               stall_req_o,
   output logic               ram_req_o,
   output logic               ram_wr_o,
   output logic [31:0]        ram_addr_o,
   output logic [ByteBus-1:0] ram_dout_o,
   input  logic [ByteBus-1:0] ram_din_i,
   input  logic               ram_ready_i
);

   state_e      state_q, state_d;
   logic [1:0]  k_q, k_d;
   logic [31:0] lbuf_q, lbuf_d;
   logic [31:0] ext_data;
   logic        op_ld, op_st;

   assign op_ld = is_load(memop_i);
   assign op_st = is_store(memop_i);

   mem_load_ext u_load_ext (
      .memop_i (memop_i),
      .buf_i   (lbuf_q),
      .data_o  (ext_data)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      lbuf_d      = lbuf_q;
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      wdata_o     = wdata_i;
      stall_req_o = 1'b0;
      ram_req_o   = 1'b0;
      ram_wr_o    = 1'b0;
      ram_addr_o  = 32'd0;
      ram_dout_o  = '0;

      case (state_q)
         ST_IDLE: begin
            if (op_ld || op_st) begin
               stall_req_o = 1'b1;
               state_d     = ST_XFER;
               k_d         = 2'd0;
               lbuf_d      = ZeroWord;
            end
         end
         ST_XFER: begin
            stall_req_o = 1'b1;
            ram_req_o   = 1'b1;
            ram_wr_o    = op_st;
            ram_addr_o  = addr_i + {30'd0, k_q};
            ram_dout_o  = sdata_i[{k_q, 3'b000} +: ByteBus];
            if (ram_ready_i) begin
               if (op_ld) lbuf_d[{k_q, 3'b000} +: ByteBus] = ram_din_i;
               k_d = k_q + 2'd1;
               if (k_q == last_byte(memop_i)) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (op_st) wreg_o = 1'b0;
      if (op_ld) wdata_o = (state_q == ST_DONE) ? ext_data : ZeroWord;

      // Outputs are forced while reset is held, not just after the flops clear.
      if (rst) begin
         wd_o        = NOPRegAddr;
         wreg_o      = WriteDisable;
         wdata_o     = ZeroWord;
         stall_req_o = 1'b0;
         ram_req_o   = 1'b0;
         ram_wr_o    = 1'b0;
         ram_addr_o  = 32'd0;
         ram_dout_o  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= 2'd0;
         lbuf_q  <= ZeroWord;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         lbuf_q  <= lbuf_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads with extension, a wrapping
// halfword store with a slow RAM, and reset abandoning a transfer.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk, rst;
   logic [4:0]  wd_i, wd_o;
   logic        wreg_i, wreg_o;
   logic [31:0] wdata_i, wdata_o;
   logic [3:0]  memop_i;
   logic [31:0] addr_i, sdata_i, ram_addr_o;
   logic        stall_req_o, ram_req_o, ram_wr_o, ram_ready_i;
   logic [7:0]  ram_dout_o, ram_din_i;
   logic [7:0]  rd_tab [4];

   int n_cmp = 0;
   int n_err = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .memop_i(memop_i), .addr_i(addr_i), .sdata_i(sdata_i), .wd_o(wd_o),
      .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
      .ram_req_o(ram_req_o), .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o),
      .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i), .ram_ready_i(ram_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM read data selected by the low address bits of the current request.
   always_comb begin
      ram_din_i = 8'h00;
      ram_din_i = rd_tab[ram_addr_o[1:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues a load with ready tied high; checks address walk, stall count, result.
   task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input int nbytes, input logic [31:0] exp);
      int stalls, nreq;
      logic addr_ok, zero_ok, done;
      @(negedge clk);
      memop_i = op; addr_i = a; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
      ram_ready_i = 1'b1;
      #1;
      stalls = 0; nreq = 0; addr_ok = 1'b1; zero_ok = 1'b1; done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (!stall_req_o) begin done = 1'b1; break; end
         stalls++;
         if (wdata_o !== 32'd0) zero_ok = 1'b0;
         if (ram_req_o) begin
            if (ram_addr_o !== a + nreq || ram_wr_o !== 1'b0) addr_ok = 1'b0;
            nreq++;
         end
         @(negedge clk); #1;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_stalls"}, stalls, nbytes + 1);
      chk({tag, "_nreq"}, nreq, nbytes);
      chk({tag, "_addr"}, {31'd0, addr_ok}, 32'd1);
      chk({tag, "_zero_before_done"}, {31'd0, zero_ok}, 32'd1);
      chk({tag, "_data"}, wdata_o, exp);
      chk({tag, "_wreg"}, {31'd0, wreg_o}, 32'd1);
      memop_i = MEM_NONE;
      ram_ready_i = 1'b0;
   endtask

   initial begin
      int stalls, b, wcnt, xfers;
      logic hold_ok, wr_ok, seen_req;

      rst = 1'b1; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hCAFE_F00D;
      memop_i = MEM_LW; addr_i = 32'h40; sdata_i = 32'hFFFF_FFFF; ram_ready_i = 1'b1;
      rd_tab[0] = 8'h11; rd_tab[1] = 8'h22; rd_tab[2] = 8'h33; rd_tab[3] = 8'h44;
      #3;
      chk("rst_wd", {27'd0, wd_o}, 32'd0);
      chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
      chk("rst_req", {31'd0, ram_req_o}, 32'd0);
      chk("rst_addr", ram_addr_o, 32'd0);

      @(negedge clk);
      memop_i = MEM_NONE; ram_ready_i = 1'b0;
      rst = 1'b0;

      // ALU pass-through, zero latency
      @(negedge clk);
      wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234_5678;
      #1;
      chk("alu_wd", {27'd0, wd_o}, 32'd5);
      chk("alu_wreg", {31'd0, wreg_o}, 32'd1);
      chk("alu_wdata", wdata_o, 32'h1234_5678);
      chk("alu_stall", {31'd0, stall_req_o}, 32'd0);
      chk("alu_req", {31'd0, ram_req_o}, 32'd0);

      // Unknown code behaves as MEM_NONE, and stray ready is ignored
      memop_i = 4'hF; ram_ready_i = 1'b1; wdata_i = 32'h0BAD_0001;
      #1;
      chk("unk_stall", {31'd0, stall_req_o}, 32'd0);
      chk("unk_wdata", wdata_o, 32'h0BAD_0001);
      @(negedge clk); #1;
      chk("unk_req_after_edge", {31'd0, ram_req_o}, 32'd0);
      memop_i = MEM_NONE; ram_ready_i = 1'b0;

      run_load("lw", MEM_LW, 32'h100, 4, 32'h4433_2211);

      rd_tab[0] = 8'h80;
      run_load("lb", MEM_LB, 32'h200, 1, 32'hFFFF_FF80);
      run_load("lbu", MEM_LBU, 32'h200, 1, 32'h0000_0080);
      rd_tab[1] = 8'hFF;
      run_load("lh", MEM_LH, 32'h300, 2, 32'hFFFF_FF80);
      run_load("lhu", MEM_LHU, 32'h300, 2, 32'h0000_FF80);

      // SH across the address wrap, two wait cycles per byte
      @(negedge clk);
      memop_i = MEM_SH; addr_i = 32'hFFFF_FFFF; sdata_i = 32'hAABB_CCDD;
      wd_i = 5'd9; wreg_i = 1'b1; ram_ready_i = 1'b0;
      #1;
      stalls = 0; b = 0; wcnt = 0; xfers = 0; hold_ok = 1'b1; wr_ok = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (wreg_o !== 1'b0 || wd_o !== 5'd9) wr_ok = 1'b0;
         if (!stall_req_o) break;
         stalls++;
         if (ram_req_o) begin
            if (ram_wr_o !== 1'b1) hold_ok = 1'b0;
            if (b == 0 && (ram_addr_o !== 32'hFFFF_FFFF || ram_dout_o !== 8'hDD)) hold_ok = 1'b0;
            if (b == 1 && (ram_addr_o !== 32'h0000_0000 || ram_dout_o !== 8'hCC)) hold_ok = 1'b0;
            if (wcnt == 2) begin ram_ready_i = 1'b1; wcnt = 0; b++; xfers++; end
            else begin ram_ready_i = 1'b0; wcnt++; end
         end else ram_ready_i = 1'b0;
         @(negedge clk); #1;
      end
      chk("sh_xfers", xfers, 2);
      chk("sh_held", {31'd0, hold_ok}, 32'd1);
      chk("sh_wreg_zero", {31'd0, wr_ok}, 32'd1);
      chk("sh_stalls", stalls, 7);
      chk("sh_done_stall", {31'd0, stall_req_o}, 32'd0);
      memop_i = MEM_NONE; ram_ready_i = 1'b0;

      // Reset during byte 2 of an LW
      rd_tab[0] = 8'h11; rd_tab[1] = 8'h22;
      @(negedge clk);
      memop_i = MEM_LW; addr_i = 32'h100; wd_i = 5'd4; wreg_i = 1'b1; ram_ready_i = 1'b1;
      #1;
      for (int c = 0; c < 10; c++) begin
         if (ram_req_o && ram_addr_o == 32'h102) break;
         @(negedge clk); #1;
      end
      chk("mid_reached_byte2", ram_addr_o, 32'h102);
      rst = 1'b1;
      #1;
      chk("mid_rst_req", {31'd0, ram_req_o}, 32'd0);
      chk("mid_rst_stall", {31'd0, stall_req_o}, 32'd0);
      chk("mid_rst_wd", {27'd0, wd_o}, 32'd0);
      chk("mid_rst_addr", ram_addr_o, 32'd0);
      memop_i = MEM_NONE;
      @(negedge clk);
      rst = 1'b0;
      seen_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         if (ram_req_o !== 1'b0 || stall_req_o !== 1'b0) seen_req = 1'b1;
      end
      chk("mid_no_more_req", {31'd0, seen_req}, 32'd0);
      wd_i = 5'd12; wreg_i = 1'b1; wdata_i = 32'h5555_AAAA; ram_ready_i = 1'b0;
      #1;
      chk("post_rst_wd", {27'd0, wd_o}, 32'd12);
      chk("post_rst_wdata", wdata_o, 32'h5555_AAAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths and encodings come from defs.v.
REQ-002 The clock is one clock; reset is asynchronous and active-high. Ports are named clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wd_i  in  5  destination register address from ex_mem.
REQ-006 wreg_i  in  1  writeback enable from ex_mem.
REQ-007 wdata_i  in  32  ALU result from ex_mem.
REQ-008 memop_i  in  4  memory operation code (MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-009 addr_i  in  32  byte address of the access.
REQ-010 sdata_i  in  32  store data.
REQ-011 wd_o  out  5  destination register to mem_wb.
REQ-012 wreg_o  out  1  writeback enable to mem_wb.
REQ-013 wdata_o  out  32  writeback data to mem_wb.
REQ-014 stall_req_o  out  1  pipeline stall request; holds ex_mem and the stages upstream of it.
REQ-015 ram_req_o  out  1  byte transfer request.
REQ-016 ram_wr_o  out  1  1 = write, 0 = read.
REQ-017 ram_addr_o  out  32  byte address.
REQ-018 ram_dout_o  out  8  write byte.
REQ-019 ram_din_i  in  8  read byte.
REQ-020 ram_ready_i  in  1  handshake acknowledge for the current byte transfer.

Function
REQ-021 FSM states SHALL be IDLE, XFER and DONE; a 2-bit byte counter k; a 32-bit load buffer buf.
REQ-022 memop_i = MEM_NONE in IDLE: wd_o/wreg_o/wdata_o SHALL equal their inputs combinationally (zero latency), stall_req_o = 0, ram_req_o = 0.
REQ-023 Any other memop_i in IDLE: stall_req_o = 1 combinationally; next state XFER; k = 0; buf = 0.
REQ-024 Byte count N SHALL be 1 for B/BU, 2 for H/HU, 4 for W/SW.
REQ-025 In XFER: ram_req_o = 1, ram_addr_o = addr_i + k (mod 2^32), ram_wr_o = 1 for stores, ram_dout_o = sdata_i[8k+7:8k] (little-endian), stall_req_o = 1.
REQ-026 Request signals SHALL stay stable until ram_ready_i is sampled high at a rising edge; a load then captures ram_din_i into buf[8k+7:8k] and k increments.
REQ-027 When ram_ready_i is sampled high with k = N-1, next state SHALL be DONE.
REQ-028 In DONE: stall_req_o = 0, ram_req_o = 0; wdata_o per REQ-029; next state IDLE unconditionally.
REQ-029 Load result SHALL be: LB sign-extend buf[7:0]; LBU zero-extend buf[7:0]; LH sign-extend buf[15:0]; LHU zero-extend buf[15:0]; LW buf.
REQ-030 Stores: wreg_o = 0 in all states; wd_o passed through.
REQ-031 Loads: wd_o = wd_i, wreg_o = wreg_i; wdata_o = ZeroWord outside DONE.
REQ-032 ram_ready_i high while ram_req_o = 0 SHALL be ignored.
REQ-033 Misaligned addresses SHALL be legal and receive no special handling.
REQ-034 Upstream holds all *_i stable while stall_req_o = 1; the block SHALL NOT re-latch inputs during a transfer.
REQ-035 Latency with ram_ready_i tied high: N+1 stall cycles, and the result is valid in the following DONE cycle.
REQ-036 An unknown memop_i code SHALL be treated as MEM_NONE.

Reset
REQ-037 While rst = 1, asynchronously: state IDLE, k = 0, buf = ZeroWord.
REQ-038 While rst = 1: wd_o = NOPRegAddr, wreg_o = WriteDisable, wdata_o = ZeroWord.
REQ-039 While rst = 1: stall_req_o = 0, ram_req_o = 0, ram_wr_o = 0, ram_addr_o = 0, ram_dout_o = 0.
REQ-040 Reset asserted mid-transfer SHALL abandon the transfer with no further RAM requests issued.

Structure
REQ-041 memop encodings (MEM_NONE = 4'h0, LB..SW) and state encodings SHALL live in defs.v; byte widths use a new ByteBus macro.
REQ-042 A combinational sub-module mem_load_ext (memop, buf -> 32-bit extended value) SHALL implement REQ-029.

Verification
REQ-043 ALU op with wd_i = 5, wreg_i = 1, wdata_i = 0x12345678 -> same values on the outputs in the same cycle; stall_req_o = 0.
REQ-044 LW at addr 0x100, ready tied high, RAM bytes 0x11/0x22/0x33/0x44 -> ram_addr_o = 0x100..0x103 and 5 stall cycles; DONE wdata_o = 0x44332211.
REQ-045 LB returning byte 0x80 -> 0xFFFFFF80; LBU -> 0x00000080; LH returning 0x80/0xFF (bytes 0, 1) -> 0xFFFFFF80.
REQ-046 SH, sdata_i = 0xAABBCCDD at 0xFFFFFFFF, ready delayed 2 cycles per byte -> byte writes 0xDD@0xFFFFFFFF then 0xCC@0x00000000 with signals held during the wait; wreg_o = 0 throughout.
REQ-047 rst pulsed during byte 2 of an LW -> outputs at reset values immediately; no further ram_req_o; next MEM_NONE passes through.
